// File: rtl/bram_power_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : bram_power_sequencer                                              |
// | Brief   : Wakes BRAM banks over a settle window and powers them down after  |
// |           a request-low hysteresis. PWR_SEQ_STAGGER_EN selects one-bank-at- |
// |           a-time wake; otherwise all pending banks wake as one group.       |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module bram_power_sequencer #(
  parameter int NUM_BANKS   = 20,
  parameter int WAKE_CYCLES = 8,
  parameter int SLEEP_HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BANKS-1:0] req_en,
  output logic [NUM_BANKS-1:0] bank_pwr,
  output logic [NUM_BANKS-1:0] bank_ready,
  output logic                 all_ready,
  output logic                 busy
);

  localparam int WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(SLEEP_HOLD + 1);
  localparam logic [WCNT_W-1:0] C_WCNT_LOAD = WCNT_W'(WAKE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(SLEEP_HOLD - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAKE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic [NUM_BANKS-1:0]   grp_q, grp_d;
  logic [NUM_BANKS-1:0]   pwr_q, pwr_d;
  logic [NUM_BANKS-1:0]   ready_q, ready_d;
  logic [HOLD_W-1:0]      hold_q [NUM_BANKS];
  logic [HOLD_W-1:0]      hold_d [NUM_BANKS];

  logic [NUM_BANKS-1:0]   w_pending;
  logic [NUM_BANKS-1:0]   w_sel;
  logic [NUM_BANKS-1:0]   w_keep;

  assign w_pending = req_en & ~pwr_q;
  assign w_keep    = grp_q & req_en;

  // The wake group is a bank mask; staggered mode narrows it to the lowest pending bank.
`ifdef PWR_SEQ_STAGGER_EN
  assign w_sel = w_pending & (~w_pending + 1'b1);
`else
  assign w_sel = w_pending;
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    grp_d   = grp_q;
    pwr_d   = pwr_q;
    ready_d = ready_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      hold_d[i] = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (|w_pending) begin
          grp_d   = w_sel;
          pwr_d   = pwr_q | w_sel;
          wcnt_d  = C_WCNT_LOAD;
          state_d = S_WAKE;
        end
      end
      S_WAKE: begin
        pwr_d = pwr_q & ~(grp_q & ~req_en);
        grp_d = w_keep;
        if (w_keep == '0) begin
          state_d = S_IDLE;
        end else if (wcnt_q == '0) begin
          ready_d = ready_q | w_keep;
          grp_d   = '0;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grp_d   = '0;
      end
    endcase

    // Ready banks are never in the wake group, so these bits never collide with the FSM.
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (ready_q[i] && !req_en[i]) begin
        if (hold_q[i] == C_HOLD_LAST) begin
          ready_d[i] = 1'b0;
          pwr_d[i]   = 1'b0;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      grp_q   <= '0;
      pwr_q   <= '0;
      ready_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      grp_q   <= grp_d;
      pwr_q   <= pwr_d;
      ready_q <= ready_d;
      for (int i = 0; i < NUM_BANKS; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign bank_pwr   = pwr_q;
  assign bank_ready = ready_q;
  assign all_ready  = &(~req_en | ready_q);
  assign busy       = (state_q == S_WAKE);

endmodule
`default_nettype wire

// File: tb/tb_bram_power_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_bram_power_sequencer                                           |
// | Brief   : Directed and random bench for bram_power_sequencer, checked       |
// |           against a timestamp-based reference model (PWR_SEQ_STAGGER_EN     |
// |           selects the staggered expectations).                              |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_bram_power_sequencer;

  localparam int NB = 20;
  localparam int WC = 8;
  localparam int SH = 4;
`ifdef PWR_SEQ_STAGGER_EN
  localparam bit STAGGER = 1'b1;
`else
  localparam bit STAGGER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] req_en = '0;
  logic [NB-1:0] bank_pwr;
  logic [NB-1:0] bank_ready;
  logic          all_ready;
  logic          busy;

  bram_power_sequencer #(
    .NUM_BANKS  (NB),
    .WAKE_CYCLES(WC),
    .SLEEP_HOLD (SH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_en    (req_en),
    .bank_pwr  (bank_pwr),
    .bank_ready(bank_ready),
    .all_ready (all_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: wake completion is judged by edge timestamps, power-down by low-run length.
  int            edge_n = 0;
  logic [NB-1:0] m_pwr = '0;
  logic [NB-1:0] m_ready = '0;
  logic [NB-1:0] m_grp = '0;
  bit            m_busy = 1'b0;
  int            m_start = 0;
  int            m_low [NB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [NB-1:0] np;
    logic [NB-1:0] nr;
    edge_n++;
    if (rst) begin
      m_pwr = '0; m_ready = '0; m_grp = '0; m_busy = 1'b0;
      for (int i = 0; i < NB; i++) m_low[i] = 0;
      return;
    end
    np = m_pwr;
    nr = m_ready;
    for (int i = 0; i < NB; i++) begin
      if (m_ready[i] && !req_en[i]) begin
        m_low[i]++;
        if (m_low[i] == SH) begin
          np[i] = 1'b0; nr[i] = 1'b0; m_low[i] = 0;
        end
      end else begin
        m_low[i] = 0;
      end
    end
    if (m_busy) begin
      for (int i = 0; i < NB; i++) begin
        if (m_grp[i] && !req_en[i]) begin
          m_grp[i] = 1'b0; np[i] = 1'b0;
        end
      end
      if (m_grp == '0) begin
        m_busy = 1'b0;
      end else if (edge_n - m_start == WC) begin
        nr = nr | m_grp; m_grp = '0; m_busy = 1'b0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (req_en[i] && !m_pwr[i] && !(STAGGER && m_grp != '0)) m_grp[i] = 1'b1;
      end
      if (m_grp != '0) begin
        np = np | m_grp; m_start = edge_n; m_busy = 1'b1;
      end
    end
    m_pwr = np;
    m_ready = nr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_en = '0;
    tick();
    rst = 1'b0;
  endtask

  logic exp_all;
  int   win_cnt;

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_all = 1'b1;
      for (int i = 0; i < NB; i++) if (req_en[i] && !m_ready[i]) exp_all = 1'b0;
      check("bank_pwr", bank_pwr, m_pwr);
      check("bank_ready", bank_ready, m_ready);
      check("busy", busy, m_busy);
      check("all_ready", all_ready, exp_all);
      check("ready_implies_pwr", bank_ready & ~bank_pwr, '0);
      if (STAGGER) begin
        win_cnt = $countones(bank_pwr & ~bank_ready);
        check("one_bank_waking", (win_cnt <= 1), 1);
      end
    end
  end

  int            n;
  int            bcnt;
  int            rdy_t [4];
  int            exp_t [4];
  logic [NB-1:0] prev_pwr;
  int            b;

  initial begin
    for (int i = 0; i < NB; i++) m_low[i] = 0;

    // Reset state
    do_reset();
    cmp_en = 1'b1;
    check("rst_pwr", bank_pwr, 0);
    check("rst_ready", bank_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_all_ready", all_ready, 1);

    // Single bank wake
    req_en = 20'h00001;
    tick();
    check("single_pwr_after_E", bank_pwr, 20'h00001);
    check("single_all_ready_low", all_ready, 0);
    bcnt = busy ? 1 : 0;
    n = 0;
    while (!bank_ready[0] && n < 20) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
    check("single_ready_latency", n, 8);
    check("single_busy_cycles", bcnt, 8);
    check("single_all_ready_high", all_ready, 1);

    // Four banks requested together
    do_reset();
    req_en = 20'h0000F;
    tick();
    prev_pwr = bank_pwr;
    for (int i = 0; i < 4; i++) rdy_t[i] = -1;
    for (int t = 1; t <= 45; t++) begin
      tick();
      for (int i = 0; i < 4; i++) if (bank_ready[i] && rdy_t[i] < 0) rdy_t[i] = t;
      if (STAGGER) check("single_pwr_rise", ($countones(bank_pwr & ~prev_pwr) <= 1), 1);
      prev_pwr = bank_pwr;
    end
    for (int i = 0; i < 4; i++) exp_t[i] = STAGGER ? (WC + 1) * i + WC : WC;
    check("wake4_bank0", rdy_t[0], exp_t[0]);
    check("wake4_bank1", rdy_t[1], exp_t[1]);
    check("wake4_bank2", rdy_t[2], exp_t[2]);
    check("wake4_bank3", rdy_t[3], exp_t[3]);

    // Sleep hysteresis on bank 2
    req_en[2] = 1'b0;
    ticks(3);
    req_en[2] = 1'b1;
    check("hyst3_pwr2", bank_pwr[2], 1);
    check("hyst3_ready2", bank_ready[2], 1);
    tick();
    req_en[2] = 1'b0;
    ticks(3);
    check("hyst4_still_on", bank_ready[2], 1);
    tick();
    check("hyst4_pwr2_off", bank_pwr[2], 0);
    check("hyst4_ready2_off", bank_ready[2], 0);

    // Abort bank 5 at wake count 3 while bank 6 becomes pending
    do_reset();
    req_en = 20'h00020;
    tick();
    ticks(4);
    req_en = 20'h00040;
    tick();
    check("abort_pwr", bank_pwr, 0);
    check("abort_ready", bank_ready, 0);
    check("abort_busy", busy, 0);
    tick();
    check("abort_next_pwr", bank_pwr, 20'h00040);
    check("abort_next_busy", busy, 1);

    // Reset in the middle of a wake
    do_reset();
    req_en = 20'h00001;
    tick();
    ticks(4);
    rst = 1'b1;
    tick();
    check("midrst_pwr", bank_pwr, 0);
    check("midrst_ready", bank_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_all_ready", all_ready, 0);
    rst = 1'b0;
    tick();
    check("midrst_restart_pwr", bank_pwr, 20'h00001);
    n = 0;
    while (!bank_ready[0] && n < 20) begin
      tick();
      n++;
    end
    check("midrst_full_wake", n, 8);

    // Random traffic
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(0, NB - 1);
        req_en[b] = ~req_en[b];
      end
      if ($urandom_range(0, 499) == 0) req_en = NB'($urandom);
      rst = ($urandom_range(0, 3999) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_power_sequencer.md
# bram_power_sequencer

- Responder side of the BRAM bank power-enable interface.
- Takes per-bank power requests from the power manager and drives the physical bank enables. Wakes banks one at a time over a fixed settle window to limit inrush current.
- Applies hysteresis before powering a bank down.
- Reports per-bank and aggregate readiness back to the requester. The requester uses this readiness to hold off compute.

## Interface
- `NUM_BANKS`, default 20: number of BRAM banks, one request and enable bit each.
- `WAKE_CYCLES`, default 8: cycles from `bank_pwr[i]` rising to `bank_ready[i]` rising. Must be ≥1.
- `SLEEP_HOLD`, default 4: consecutive cycles a request must stay low before a ready bank powers down. Must be ≥1.

Ports:
- `clk`  in  1: the block's single clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_en`  in  NUM_BANKS: power request per bank, level-sensitive, from the power manager.
- `bank_pwr`  out  NUM_BANKS: physical power/enable to each BRAM bank.
- `bank_ready`  out  NUM_BANKS: bank powered and settled, safe to access.
- `all_ready`  out  1: every requested bank is ready.
- `busy`  out  1: a wake sequence is in progress.

## Operation
- FSM has two states, `S_IDLE` and `S_WAKE`. It owns a wake counter `wcnt` and a current-bank index `cur`.
- Transitions out of `S_IDLE`:
  - A bank is pending when `req_en[i]=1` and `bank_pwr[i]=0`.
  - If any bank is pending, select the lowest pending index as `cur`, set `bank_pwr[cur]`, load `wcnt=WAKE_CYCLES-1`, and go to `S_WAKE`.
- Behaviour in `S_WAKE`:
  - If `req_en[cur]=0`, abort: clear `bank_pwr[cur]`, leave `bank_ready[cur]` at 0, return to `S_IDLE`.
  - Otherwise, if `wcnt==0`, set `bank_ready[cur]` and return to `S_IDLE`.
  - Otherwise, decrement `wcnt`.
- Requests arriving during `S_WAKE` wait for the next `S_IDLE` selection. Lowest index always wins.
- Power-down runs per bank, in parallel with the FSM, using a hold counter per bank:
  - While `bank_ready[i]=1` and `req_en[i]=0`, increment `hold[i]`.
  - Any cycle with `req_en[i]=1` clears `hold[i]`.
  - When `hold[i]` reaches `SLEEP_HOLD`, clear `bank_ready[i]` and `bank_pwr[i]` on the same edge and clear `hold[i]`.
- Invariant: `bank_ready[i]=1` implies `bank_pwr[i]=1`.
- `all_ready` is combinational: AND over i of (`!req_en[i]` or `bank_ready[i]`). With no requests it is 1.
- `busy` is combinational: `state==S_WAKE`.
- Reset values: `bank_pwr=0`, `bank_ready=0`, `busy=0`, state `S_IDLE`, all counters 0. `all_ready` follows its combinational definition, so with `req_en=0` it reads 1.

## Timing
- Sampling edge E is the edge at which `S_IDLE` samples a pending bank.
  - `bank_pwr[i]` is high after E.
  - `bank_ready[i]` is high after E+WAKE_CYCLES.
  - The FSM is back in `S_IDLE` after E+WAKE_CYCLES, and the next selection happens at E+WAKE_CYCLES+1.
- Staggered wake of k banks requested together: bank j (1-based, ascending index) is ready (WAKE_CYCLES+1)·(j-1)+WAKE_CYCLES cycles after E.
- Power-down: the request falls before edge F. The bank's power and ready are low after edge F+SLEEP_HOLD-1, i.e. after SLEEP_HOLD consecutive sampled-low cycles.
- Simultaneous events:
  - Wake completion and another bank's power-down on the same edge both take effect.
  - An abort and a new pending bank on the same edge: the abort takes priority, and selection happens next cycle.
- Reset asserted mid-wake: at the next edge all outputs and state return to reset values, with no completion.

## Configuration
- `PWR_SEQ_STAGGER_EN` defined: one-bank-at-a-time staggered wake, as described above.
- `PWR_SEQ_STAGGER_EN` undefined: group wake.
  - `S_IDLE` powers all pending banks on the same edge and latches them as the group.
  - All banks in the group become ready together after `WAKE_CYCLES`.
  - A bank whose request drops mid-wake is removed individually (power cleared). If the group empties, return to `S_IDLE`.
  - Banks requested during `S_WAKE` join the next group.
- Power-down, `all_ready` and `busy` are identical in both modes.

## Test plan
- Reset, then `req_en=0x00001`, `WAKE_CYCLES=8` → `bank_pwr[0]`=1 one edge after the sampling edge, `bank_ready[0]`=1 exactly 8 cycles later, `busy` high for 8 cycles, `all_ready` 0→1.
- `req_en=0x0000F` in one cycle, staggered → ready for banks 0, 1, 2, 3 at 8, 17, 26, 35 cycles after E. `bank_pwr` never rises for two banks on the same edge. Repeat undefined → all four ready at cycle 8.
- Ready bank 2: drop the request for 3 cycles then reassert → stays powered. Drop it for 4 cycles → `bank_pwr[2]`=`bank_ready[2]`=0 after the 4th low sample.
- Drop `req_en[5]` at wake count 3 → `bank_pwr[5]` low the next cycle, `bank_ready[5]` never set, FSM in `S_IDLE`, next pending bank selected on the following edge.
- Assert `rst` during the 5th cycle of a wake → all outputs 0 after the next edge. After release, the wake restarts and takes the full 8 cycles.
- Random request traffic for 10k cycles → `bank_ready[i]=1` implies `bank_pwr[i]=1`. At most one bank in the wake window when staggered. `all_ready` matches the reference model every cycle.
